ysyx_23060061_ifu: RTL

//  Instruction fetch unit; sits directly upstream of the core datapath and drives its inst/pc inputs.

---
 rtl/ysyx_23060061_ifu_pkg.sv | 23 ++
 rtl/ysyx_23060061_Reg.sv | 21 ++
 rtl/ysyx_23060061_ifu.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060061_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// bus response codes, default widths and the reset PC.
package ysyx_23060061_ifu_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    S_AR   = 3'd0,
    S_R    = 3'd1,
    S_OUT  = 3'd2,
    S_WAIT = 3'd3,
    S_ERR  = 3'd4
  } ifu_state_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060061_Reg.sv
// Generic enabled register with asynchronous active-high reset.
//  clk, rst  : clock, async reset (loads RESET_VAL)
//  wen, din  : write enable and data
//  dout      : registered value
module ysyx_23060061_Reg #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// Non-pipelined instruction fetch unit. Holds the PC, fetches one word over
// a read-address/read-data valid/ready bus, presents {pc, inst} to decode,
// then waits for dnpc from execute before the next fetch.
//  araddr/arvalid/arready         : fetch address channel
//  rdata/rresp/rvalid/rready      : fetch data channel
//  inst/pc/inst_valid/inst_ready  : decode-side handshake
//  dnpc/dnpc_valid                : next PC from execute
//  fetch_err                      : sticky bus error / misaligned dnpc
module ysyx_23060061_ifu
  import ysyx_23060061_ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [ADDR_W-1:0] dnpc,
  input  logic              dnpc_valid,
  output logic              fetch_err
);

  ifu_state_t state, state_nxt;
  logic       pc_wen;
  logic       inst_wen;
  logic       err_set;

  // Architectural PC; only written when execute hands back dnpc.
  ysyx_23060061_Reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (pc_wen),
    .din  (dnpc),
    .dout (pc)
  );

  // The PC register is stable for the whole S_AR phase, so it is the address.
  assign araddr = pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_AR;
    else     state <= state_nxt;
  end

  // Instruction latch and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (inst_wen) inst <= rdata;
      if (err_set)  fetch_err <= 1'b1;
    end
  end

  // Next-state and handshake decode; handshakes are forced low during reset.
  always_comb begin
    state_nxt  = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    pc_wen     = 1'b0;
    inst_wen   = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          if (rresp == RESP_OKAY) begin
            inst_wen  = 1'b1;
            state_nxt = S_OUT;
          end else begin
            err_set   = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
      S_OUT: begin
        inst_valid = 1'b1;
        if (inst_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A misaligned dnpc is still recorded in pc so it can be inspected.
        if (dnpc_valid) begin
          pc_wen = 1'b1;
          if (is_misaligned(dnpc[1:0])) begin
            err_set   = 1'b1;
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_AR;
          end
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_AR;
    endcase
    if (rst) begin
      arvalid    = 1'b0;
      rready     = 1'b0;
      inst_valid = 1'b0;
    end
  end

endmodule
